// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential requests to imem, in-order
// response FIFO carrying {pc, inst}, and redirect with flush plus stale-response dropping.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STEP  = XLEN'(INST_BYTES);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;
    logic [CW-1:0]   outstanding_retired;
    logic [XLEN-1:0] buf_data [FIFO_DEPTH];
    logic [XLEN-1:0] buf_pc   [FIFO_DEPTH];

    logic fifo_empty;
    logic req_fire;
    logic rsp_keep;
    logic rsp_drop;
    logic push;
    logic pop;

    assign fifo_count   = wr_ptr - rd_ptr;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    // Requests still in flight occupy a FIFO slot so every response is guaranteed room.
    assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};

    assign imem_req_valid = !rst && !redirect_valid && (credits_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0);
    assign push     = rsp_keep && !redirect_valid;

    assign inst_valid = !rst && !fifo_empty;
    assign inst_data  = buf_data[rd_ptr[AW-1:0]];
    assign inst_pc    = buf_pc[rd_ptr[AW-1:0]];
    assign pop        = inst_valid && inst_ready;

    assign outstanding_retired = outstanding - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle's response belongs to the old path.
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= outstanding_retired;
            drop_cnt    <= outstanding_retired;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + STEP;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
                rsp_pc <= rsp_pc + STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_data[wr_ptr[AW-1:0]] <= imem_rsp_data;
            buf_pc[wr_ptr[AW-1:0]]   <= rsp_pc;
        end
    end

    a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credits_used <= DEPTH_W);
    a_drop_bound: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle vector table plus memory-model sequences for
// back-pressure, redirect dropping, random request stalls with wrap, and mid-burst reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rdv;
        logic [31:0] rdpc;
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] rsp_pc;
        logic        i_rdy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t        vt [15];
    mreq_t       mq [$];
    logic [31:0] acc [$];
    logic [31:0] got_pc [$];
    logic [31:0] got_data [$];
    int          cyc = 0;
    int          lat = 1;
    logic        obs_rqv, obs_iv, prev_stall;
    logic [31:0] obs_addr, prev_addr;

    function automatic logic [31:0] dat(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        mq.delete();
        prev_stall = 1'b0;
        #1;
        chk("rst inst_valid", 32'(inst_valid), 0);
        chk("rst req_valid", 32'(imem_req_valid), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock of the memory model: fixed-latency in-order responder.
    task automatic cycle();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = dat(mq[0].addr);
        end
        #1;
        obs_rqv  = imem_req_valid;
        obs_addr = imem_req_addr;
        obs_iv   = inst_valid;
        if (prev_stall && !redirect_valid) begin
            chk("held req_valid", 32'(obs_rqv), 1);
            chk("held req_addr", obs_addr, prev_addr);
        end
        prev_stall = obs_rqv && !imem_req_ready;
        prev_addr  = obs_addr;
        if (obs_rqv && imem_req_ready) begin
            acc.push_back(obs_addr);
            mq.push_back('{obs_addr, cyc + lat});
        end
        if (obs_iv && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_data.push_back(inst_data);
        end
        if (imem_rsp_valid) void'(mq.pop_front());
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic clear_logs();
        acc.delete();
        got_pc.delete();
        got_data.delete();
    endtask

    task automatic check_stream(input string name, input logic [31:0] start, input int min_n);
        logic [31:0] exp;
        chk({name, " count"}, 32'(got_pc.size() >= min_n), 1);
        for (int k = 0; k < got_pc.size(); k++) begin
            exp = start + 32'(4 * k);
            chk($sformatf("%s pc[%0d]", name, k), got_pc[k], exp);
            chk($sformatf("%s data[%0d]", name, k), got_data[k], dat(exp));
        end
    endtask

    task automatic check_acc(input string name, input logic [31:0] start);
        for (int k = 0; k < acc.size(); k++) begin
            chk($sformatf("%s addr[%0d]", name, k), acc[k], start + 32'(4 * k));
        end
    endtask

    initial begin
        //        rdv  rdpc       rq  rspv rsp_pc     irdy  e_rqv e_addr     e_iv e_ipc
        vt[0]  = '{0, 32'h0,    1, 0, 32'h0,    1,    1, 32'h0,    0, 32'h0};
        vt[1]  = '{0, 32'h0,    1, 1, 32'h0,    1,    1, 32'h4,    0, 32'h0};
        vt[2]  = '{0, 32'h0,    1, 1, 32'h4,    1,    1, 32'h8,    1, 32'h0};
        vt[3]  = '{0, 32'h0,    1, 1, 32'h8,    0,    1, 32'hC,    1, 32'h4};
        vt[4]  = '{0, 32'h0,    1, 1, 32'hC,    0,    1, 32'h10,   1, 32'h4};
        vt[5]  = '{0, 32'h0,    1, 1, 32'h10,   0,    0, 32'h0,    1, 32'h4};
        vt[6]  = '{0, 32'h0,    1, 0, 32'h0,    0,    0, 32'h0,    1, 32'h4};
        vt[7]  = '{0, 32'h0,    1, 0, 32'h0,    1,    0, 32'h0,    1, 32'h4};
        vt[8]  = '{0, 32'h0,    1, 0, 32'h0,    1,    1, 32'h14,   1, 32'h8};
        vt[9]  = '{0, 32'h0,    1, 1, 32'h14,   1,    1, 32'h18,   1, 32'hC};
        vt[10] = '{0, 32'h0,    1, 0, 32'h0,    1,    1, 32'h1C,   1, 32'h10};
        vt[11] = '{1, 32'h200,  1, 1, 32'h18,   1,    0, 32'h0,    1, 32'h14};
        vt[12] = '{0, 32'h0,    1, 1, 32'h1C,   1,    1, 32'h200,  0, 32'h0};
        vt[13] = '{0, 32'h0,    1, 1, 32'h200,  1,    1, 32'h204,  0, 32'h0};
        vt[14] = '{0, 32'h0,    1, 0, 32'h0,    1,    1, 32'h208,  1, 32'h200};

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        inst_ready = 1'b0;
        prev_stall = 1'b0;
        do_reset();

        // Fill, stall to full, release, redirect coincident with response and pop.
        for (int i = 0; i < 15; i++) begin
            redirect_valid = vt[i].rdv;
            redirect_pc    = vt[i].rdpc;
            imem_req_ready = vt[i].rq_rdy;
            imem_rsp_valid = vt[i].rsp_v;
            imem_rsp_data  = dat(vt[i].rsp_pc);
            inst_ready     = vt[i].i_rdy;
            #1;
            chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_rqv));
            if (vt[i].e_rqv) chk($sformatf("vec%0d req_addr", i), imem_req_addr, vt[i].e_addr);
            chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vt[i].e_iv));
            if (vt[i].e_iv) begin
                chk($sformatf("vec%0d inst_pc", i), inst_pc, vt[i].e_ipc);
                chk($sformatf("vec%0d inst_data", i), inst_data, dat(vt[i].e_ipc));
            end
            @(posedge clk); #1;
            if (i == 11) chk("vec11 drop_cnt", 32'(dut.drop_cnt), 1);
        end
        imem_rsp_valid = 1'b0;

        // Back-pressure: only FIFO_DEPTH requests go out, then resume at 0x10.
        do_reset();
        lat = 1; inst_ready = 1'b0; imem_req_ready = 1'b1;
        clear_logs();
        repeat (12) cycle();
        chk("bp accepted", 32'(acc.size()), 4);
        chk("bp req_valid", 32'(obs_rqv), 0);
        inst_ready = 1'b1;
        repeat (20) cycle();
        chk("bp resume addr", acc[4], 32'h10);
        check_acc("bp", 32'h0);
        check_stream("bp", 32'h0, 16);

        // Three in flight at latency 4, redirect to 0x100.
        do_reset();
        lat = 4; inst_ready = 1'b1; imem_req_ready = 1'b1;
        clear_logs();
        repeat (3) cycle();
        chk("rd in flight", 32'(acc.size()), 3);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        chk("rd N req_valid", 32'(obs_rqv), 0);
        redirect_valid = 1'b0;
        clear_logs();
        cycle();
        chk("rd N+1 req_valid", 32'(obs_rqv), 1);
        chk("rd N+1 req_addr", obs_addr, 32'h100);
        chk("rd N+1 inst_valid", 32'(obs_iv), 0);
        repeat (20) cycle();
        check_stream("rd", 32'h100, 8);

        // Random request stalls, random decode stalls, PC wrap through zero.
        do_reset();
        lat = 2; inst_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
        cycle();
        redirect_valid = 1'b0;
        clear_logs();
        for (int n = 0; n < 300; n++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            inst_ready     = ($urandom_range(0, 3) != 0);
            cycle();
        end
        chk("wrap reached", 32'(acc.size() >= 8), 1);
        check_acc("wrap", 32'hFFFF_FFF0);
        check_stream("wrap", 32'hFFFF_FFF0, 8);

        // Reset mid-burst: two buffered, two outstanding.
        do_reset();
        lat = 3; inst_ready = 1'b0; imem_req_ready = 1'b1;
        clear_logs();
        repeat (5) cycle();
        chk("pre-rst fifo_count", 32'(dut.fifo_count), 2);
        chk("pre-rst outstanding", 32'(dut.outstanding), 2);
        do_reset();
        #1;
        chk("post-rst inst_valid", 32'(inst_valid), 0);
        chk("post-rst req_valid", 32'(imem_req_valid), 1);
        chk("post-rst req_addr", imem_req_addr, 32'h0);
        chk("post-rst outstanding", 32'(dut.outstanding), 0);
        chk("post-rst drop_cnt", 32'(dut.drop_cnt), 0);
        chk("post-rst fifo_count", 32'(dut.fifo_count), 0);
        inst_ready = 1'b1;
        clear_logs();
        repeat (10) cycle();
        check_stream("post-rst", 32'h0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
